// File: rtl/i_cache_pkg.sv
// Shared types and default geometry for the direct-mapped I-cache.
// Imported by the cache top and its line store.
package i_cache_pkg;

  localparam int IDX_BITS_DEF   = 6;
  localparam int OFF_LOG2_DEF   = 2;
  localparam int BYTE_OFF_BITS  = 2;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_RESP
  } state_e;

  function automatic int tag_bits(input int idx_b, input int off_b);
    return 32 - idx_b - off_b - BYTE_OFF_BITS;
  endfunction

endpackage

// File: rtl/i_cache_line_store.sv
// Valid/tag/data flop arrays of the I-cache.
// Combinational read by index; only valid bits are reset.
module i_cache_line_store
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS        = IDX_BITS_DEF,
  parameter int OFFSET_WORDS_LOG2 = OFF_LOG2_DEF,
  parameter int TAG_BITS          = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [(1<<OFFSET_WORDS_LOG2)-1:0][31:0] rd_line,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [(1<<OFFSET_WORDS_LOG2)-1:0] word_we,
  input  logic [31:0]           wr_data,
  input  logic                  tag_we,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic                  inv_we
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << OFFSET_WORDS_LOG2;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [WORDS-1:0][31:0] data_q [LINES];

  always_comb begin
    valid_d = valid_q;
    if (inv_we) valid_d[wr_idx] = 1'b0;
    if (tag_we) valid_d[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_q[wr_idx] <= wr_tag;
    for (int w = 0; w < WORDS; w++) begin
      if (word_we[w]) data_q[wr_idx][w] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/i_cache_dm.sv
// Direct-mapped read-only instruction cache between the CPU
// sram-like fetch port and the AXI bridge sram-like port.
module i_cache_dm
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS        = IDX_BITS_DEF,
  parameter int OFFSET_WORDS_LOG2 = OFF_LOG2_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_BITS =
    tag_bits(INDEX_BITS, OFFSET_WORDS_LOG2);
  localparam int WORDS = 1 << OFFSET_WORDS_LOG2;
  localparam int IDX_LO = OFFSET_WORDS_LOG2 + BYTE_OFF_BITS;

  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [OFFSET_WORDS_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [TAG_BITS-1:0] tag_f;
  logic [INDEX_BITS-1:0] idx_f;
  logic [OFFSET_WORDS_LOG2-1:0] word_f;

  logic rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [WORDS-1:0][31:0] rd_line;
  logic [WORDS-1:0] word_we;
  logic tag_we, inv_we, hit;

  logic unused_ok;
  assign unused_ok = ^{cpu_inst_wr, cpu_inst_size,
                       cpu_inst_wdata, cpu_inst_addr[1:0]};

  assign tag_f  = addr_q[31 -: TAG_BITS];
  assign idx_f  = addr_q[IDX_LO +: INDEX_BITS];
  assign word_f = addr_q[BYTE_OFF_BITS +: OFFSET_WORDS_LOG2];
  assign hit    = rd_valid && (rd_tag == tag_f);

  i_cache_line_store #(
    .INDEX_BITS       (INDEX_BITS),
    .OFFSET_WORDS_LOG2(OFFSET_WORDS_LOG2),
    .TAG_BITS         (TAG_BITS)
  ) u_store (
    .clk     (clk),
    .rst_n   (resetn),
    .rd_idx  (idx_f),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_idx  (idx_f),
    .word_we (word_we),
    .wr_data (cache_inst_rdata),
    .tag_we  (tag_we),
    .wr_tag  (tag_f),
    .inv_we  (inv_we)
  );

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    cnt_d            = cnt_q;
    resp_d           = resp_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = '0;
    cache_inst_req   = 1'b0;
    word_we          = '0;
    tag_we           = 1'b0;
    inv_we           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cpu_inst_addr_ok = cpu_inst_req;
        if (cpu_inst_req) begin
          addr_d  = {cpu_inst_addr[31:2], 2'b00};
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = rd_line[word_f];
          hit_cnt_d        = hit_cnt_q + 32'd1;
          state_d          = S_IDLE;
        end else begin
          // drop the line now so an aborted refill leaves it invalid
          miss_cnt_d = miss_cnt_q + 32'd1;
          cnt_d      = '0;
          inv_we     = 1'b1;
          state_d    = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        cache_inst_req = 1'b1;
        if (cache_inst_addr_ok) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (cache_inst_data_ok) begin
          word_we[cnt_q] = 1'b1;
          if (cnt_q == word_f) resp_d = cache_inst_rdata;
          if (cnt_q == {OFFSET_WORDS_LOG2{1'b1}}) begin
            tag_we  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_REFILL_REQ;
          end
        end
      end
      S_RESP: begin
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = resp_q;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      resp_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cache_inst_addr  = {addr_q[31:IDX_LO], cnt_q, 2'b00};
  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = SIZE_WORD;
  assign cache_inst_wdata = '0;
  assign hit_cnt          = hit_cnt_q;
  assign miss_cnt         = miss_cnt_q;

endmodule

// File: tb/tb_i_cache_dm.sv
// Bench for i_cache_dm: directed + random fetches against a
// line-level cache model and a word-addressed memory model.
module tb_i_cache_dm;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_inst_req;
  logic        cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_wdata;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  bit          m_valid [64];
  logic [21:0] m_tag [64];
  int unsigned m_hits, m_miss;

  always #5 clk = ~clk;

  i_cache_dm dut (
    .clk               (clk),
    .resetn            (resetn),
    .cpu_inst_req      (cpu_inst_req),
    .cpu_inst_wr       (cpu_inst_wr),
    .cpu_inst_size     (cpu_inst_size),
    .cpu_inst_addr     (cpu_inst_addr),
    .cpu_inst_wdata    (cpu_inst_wdata),
    .cpu_inst_rdata    (cpu_inst_rdata),
    .cpu_inst_addr_ok  (cpu_inst_addr_ok),
    .cpu_inst_data_ok  (cpu_inst_data_ok),
    .cache_inst_req    (cache_inst_req),
    .cache_inst_wr     (cache_inst_wr),
    .cache_inst_size   (cache_inst_size),
    .cache_inst_addr   (cache_inst_addr),
    .cache_inst_wdata  (cache_inst_wdata),
    .cache_inst_rdata  (cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok),
    .cache_inst_data_ok(cache_inst_data_ok),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a[31:4] == 28'h1FC0000) return 32'hA0 + {30'd0, a[3:2]};
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd0);
    check({tag, "_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
    check({tag, "_cache_req"}, {31'd0, cache_inst_req}, 32'd0);
    check({tag, "_rdata"}, cpu_inst_rdata, 32'd0);
    check({tag, "_hit_cnt"}, hit_cnt, 32'd0);
    check({tag, "_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  // first_stall < 0 picks a random addr_ok delay; abort_after > 0
  // resets the DUT once that many refill words have been returned
  task automatic fetch(input logic [31:0] a, input int first_stall,
                       input int abort_after);
    int acc_n, dok_n, req_n, dat_n, cyc;
    int acc_cyc, dok_cyc, last_dat;
    int lat, stall;
    bit phase, exp_hit;
    logic [31:0] got, aw;
    int idx;
    logic [21:0] tg;
    aw = {a[31:2], 2'b00};
    idx = int'(a[9:4]);
    tg = a[31:10];
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    acc_n = 0; dok_n = 0; req_n = 0; dat_n = 0; cyc = 0;
    acc_cyc = -1; dok_cyc = -1; last_dat = -1;
    lat = 0; phase = 1'b0; got = '0;
    stall = (first_stall >= 0) ? first_stall : $urandom_range(0, 2);
    @(negedge clk);
    cpu_inst_req = 1'b1;
    cpu_inst_addr = {a[31:2], 2'($urandom)};
    while (dok_n == 0 && cyc < 300) begin
      if (cyc > 0) @(negedge clk);
      if (abort_after > 0 && dat_n == abort_after && !phase) begin
        cpu_inst_req = 1'b0;
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;
        resetn = 1'b0;
        #1;
        check("abort_accepted", acc_n, 1);
        check("abort_no_resp", dok_n, 0);
        check_reset_outputs("abort");
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("release");
        return;
      end
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      cache_inst_rdata = $urandom;
      if (phase) begin
        if (lat == 0) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata = mem_val(aw & 32'hFFFF_FFF0 |
                                     (32'(dat_n) << 2));
          phase = 1'b0;
          dat_n++;
          last_dat = cyc;
        end else lat--;
      end else if (cache_inst_req) begin
        check("refill_addr", cache_inst_addr,
              {aw[31:4], req_n[1:0], 2'b00});
        if (stall == 0) begin
          cache_inst_addr_ok = 1'b1;
          phase = 1'b1;
          lat = $urandom_range(0, 2);
          req_n++;
          stall = $urandom_range(0, 2);
        end else stall--;
      end else if ($urandom_range(0, 3) == 0) begin
        cache_inst_data_ok = 1'b1;
      end
      #1;
      if (cpu_inst_addr_ok) begin
        acc_n++;
        acc_cyc = cyc;
      end
      if (cpu_inst_data_ok) begin
        dok_n++;
        dok_cyc = cyc;
        got = cpu_inst_rdata;
      end
      cyc++;
    end
    cpu_inst_req = 1'b0;
    cache_inst_data_ok = 1'b0;
    check("accept_once", acc_n, 1);
    check("accept_cycle", acc_cyc, 0);
    check("data_ok_once", dok_n, 1);
    check("rdata", got, mem_val(aw));
    if (exp_hit) begin
      check("hit_no_refill", req_n, 0);
      check("hit_latency", dok_cyc, 1);
      m_hits++;
    end else begin
      check("miss_refills", req_n, 4);
      check("miss_latency", dok_cyc, last_dat + 1);
      m_miss++;
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
    end
    @(posedge clk);
    #1;
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_miss);
  endtask

  initial begin
    int unsigned h0, m0;
    logic [31:0] ra;
    resetn = 1'b0;
    cpu_inst_req = 1'b0;
    cpu_inst_wr = 1'b0;
    cpu_inst_size = 2'b10;
    cpu_inst_addr = '0;
    cpu_inst_wdata = '0;
    cache_inst_rdata = '0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    check("cache_wr", {31'd0, cache_inst_wr}, 32'd0);
    check("cache_size", {30'd0, cache_inst_size}, 32'd2);
    check("cache_wdata", cache_inst_wdata, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    fetch(32'h1FC0_0004, -1, 0);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    fetch(32'h1FC0_000C, -1, 0);
    check("warm_hit_cnt", hit_cnt, 32'd1);
    fetch(32'h1FC0_0400, -1, 0);
    fetch(32'h1FC0_0004, -1, 0);
    check("conflict_miss_cnt", miss_cnt, 32'd3);

    fetch(32'h1FC0_1008, 5, 0);

    fetch(32'h1FC0_2000, -1, 2);
    fetch(32'h1FC0_2004, -1, 0);
    check("post_abort_miss", miss_cnt, 32'd1);

    h0 = m_hits;
    m0 = m_miss;
    for (int i = 0; i < 16; i++) fetch(32'h1FC0_0000 + 4 * i, -1, 0);
    check("stream_misses", miss_cnt - m0, 32'd4);
    check("stream_hits", hit_cnt - h0, 32'd12);

    for (int i = 0; i < 40; i++) begin
      ra = 32'h1FC0_0000
         | (32'($urandom_range(0, 2)) << 10)
         | (32'($urandom_range(0, 7)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fetch(ra, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_cache_dm.md
Name: i_cache_dm

Overview:
Direct-mapped, read-only instruction cache that replaces the pass-through instruction path of the dummy cache. It sits between the instruction sram-like port of i_sram2sramlike (CPU side) and the instruction sram-like port of cpu_axi_interface (memory side). Hits are served from on-chip flops. Misses refill one full line with sequential single-word sram-like reads and return the requested word at the end of the refill.

Parameters:
INDEX_BITS, 6, log2 of line count (64 lines)
OFFSET_WORDS_LOG2, 2, log2 of words per line (4 words, 16 B)
TAG_BITS, derived = 32-INDEX_BITS-OFFSET_WORDS_LOG2-2, tag width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cpu_inst_req  in  1  CPU fetch request, held until addr_ok
cpu_inst_wr  in  1  write flag; must be 0, ignored
cpu_inst_size  in  2  ignored; word fetch only
cpu_inst_addr  in  32  fetch physical address; bits [1:0] ignored
cpu_inst_wdata  in  32  ignored
cpu_inst_rdata  out  32  fetched word, valid while cpu_inst_data_ok=1
cpu_inst_addr_ok  out  1  request accepted this cycle
cpu_inst_data_ok  out  1  one-cycle pulse, response valid
cache_inst_req  out  1  refill request to the AXI interface
cache_inst_wr  out  1  constant 0
cache_inst_size  out  2  constant 2'b10
cache_inst_addr  out  32  refill word address
cache_inst_wdata  out  32  constant 0
cache_inst_rdata  in  32  refill data
cache_inst_addr_ok  in  1  refill request accepted
cache_inst_data_ok  in  1  refill data valid
hit_cnt  out  32  hit counter, wraps
miss_cnt  out  32  miss counter, wraps

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all valid bits=0; word counter=0; hit_cnt=0, miss_cnt=0.
  - cpu_inst_addr_ok=0, cpu_inst_data_ok=0, cache_inst_req=0, cpu_inst_rdata=0.
  - Tag and data arrays are not reset.
- Address split: tag=addr[31:32-TAG_BITS]; index=addr[INDEX_BITS+OFFSET_WORDS_LOG2+1 : OFFSET_WORDS_LOG2+2]; word=addr[OFFSET_WORDS_LOG2+1:2].
- IDLE:
  - cpu_inst_addr_ok = cpu_inst_req (combinational).
  - On acceptance, latch the address → LOOKUP.
- LOOKUP:
  - Combinational compare valid[index] && tag_array[index]==latched tag.
  - Hit: cpu_inst_data_ok=1, cpu_inst_rdata=data[index][word], hit_cnt+1 → IDLE.
  - Miss: miss_cnt+1, cnt=0, valid[index]=0 → REFILL_REQ.
- REFILL_REQ:
  - cache_inst_req=1, cache_inst_addr={latched tag, index, cnt, 2'b00}.
  - Request is held stable until cache_inst_addr_ok=1 → REFILL_WAIT.
- REFILL_WAIT:
  - On cache_inst_data_ok: data[index][cnt]=cache_inst_rdata; if cnt==word, also capture the word into the response register.
  - If cnt==2^OFFSET_WORDS_LOG2-1: tag_array[index]=tag, valid[index]=1 → RESP. Otherwise cnt+1 → REFILL_REQ.
  - cache_inst_addr_ok is ignored in this state.
- RESP: cpu_inst_data_ok=1, cpu_inst_rdata=response register → IDLE.
- Latency:
  - Hit: addr_ok at cycle 0, data_ok at cycle 1.
  - Miss: data_ok one cycle after the last refill data_ok.
  - At most one CPU request outstanding; addr_ok is asserted only in IDLE.
- Simultaneous events:
  - cpu_inst_req high in LOOKUP/RESP is not accepted until the next IDLE cycle.
  - cache_inst_data_ok outside REFILL_WAIT is ignored.
- cpu_inst_data_ok is never asserted in the same cycle as cpu_inst_addr_ok.
- Reset mid-refill: immediately IDLE; the partially refilled line stays invalid because it was invalidated at the miss.
- Counters wrap at 2^32.

Decomposition:
- Package i_cache_pkg: state encoding (IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP), default geometry constants, and address-field slice widths.
- Sub-module i_cache_line_store: valid/tag/data flop arrays.
  - Read port: combinational, by index.
  - Write ports: one per word, plus a tag/valid write, plus an invalidate.
  - Async clear of the valid bits.

Test Plan:
- Cold miss: fetch 0x1FC00004 → four refill reqs at 0x1FC00000/04/08/0C, data 0xA0,0xA1,0xA2,0xA3 → cpu_inst_rdata=0xA1 one cycle after the 4th data_ok; miss_cnt=1.
- Hit after fill: fetch 0x1FC0000C → data_ok one cycle after addr_ok, rdata=0xA3, no cache_inst_req; hit_cnt=1.
- Conflict: fetch 0x1FC00400 (same index, new tag) → refill; then fetch 0x1FC00004 → miss again; miss_cnt=3.
- Back-pressure: hold cache_inst_addr_ok=0 for 5 cycles → cache_inst_req and cache_inst_addr stay stable, no cpu_inst_data_ok.
- Reset mid-refill: resetn=0 after 2nd refill data_ok, then release and refetch the same line → full 4-word miss, valid bits were cleared; counters=0 at release.
- Streaming: 16 sequential fetches from 0x1FC00000 → 4 misses, 12 hits; every returned word matches memory model.
